// File: rtl/mem_dma_engine_pkg.sv
// Shared SoC definitions for the memory DMA engine: default widths, FSM states
// and the address-region tags carried in the top address bits.
package mem_dma_engine_pkg;

    localparam int DMA_ADDR_W = 19;
    localparam int DMA_DATA_W = 19;
    localparam int DMA_LEN_W  = 11;

    // Region tags live in address bits [18:16]; the engine does not police them.
    localparam logic [2:0] REGION_FFT    = 3'b111;
    localparam logic [2:0] REGION_CRYPTO = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } dma_state_e;

endpackage

// File: rtl/mem_dma_engine.sv
// Single-channel memory DMA: word-by-word copy (read then write) or constant fill,
// with abort and a one-cycle done pulse. Memory-side outputs decode only from registers.
module mem_dma_engine
    import mem_dma_engine_pkg::*;
#(
    parameter int ADDR_W = DMA_ADDR_W,
    parameter int DATA_W = DMA_DATA_W,
    parameter int LEN_W  = DMA_LEN_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  length,
    input  logic [DATA_W-1:0] fill_data,
    input  logic              abort,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] write_data,
    input  logic [DATA_W-1:0] read_data,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  words_done
);

    dma_state_e        state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [LEN_W-1:0]  words_q, words_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] fill_q, fill_d;
    logic              mode_q, mode_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            words_q <= '0;
            data_q  <= '0;
            fill_q  <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            words_q <= words_d;
            data_q  <= data_d;
            fill_q  <= fill_d;
            mode_q  <= mode_d;
        end
    end

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        rem_d   = rem_q;
        words_d = words_q;
        data_d  = data_q;
        fill_d  = fill_q;
        mode_d  = mode_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    src_d   = src_addr;
                    dst_d   = dst_addr;
                    rem_d   = length;
                    mode_d  = mode;
                    fill_d  = fill_data;
                    words_d = '0;
                    if (length == '0)
                        state_d = ST_DONE;
                    else
                        state_d = mode ? ST_WR : ST_RD;
                end
            end
            ST_RD: begin
                data_d  = read_data;
                state_d = abort ? ST_IDLE : ST_WR;
            end
            ST_WR: begin
                // The write strobed this cycle lands even on abort, so the
                // bookkeeping advances unconditionally.
                src_d   = src_q + 1'b1;
                dst_d   = dst_q + 1'b1;
                words_d = words_q + 1'b1;
                rem_d   = rem_q - 1'b1;
                if (abort)
                    state_d = ST_IDLE;
                else if (rem_q == LEN_W'(1))
                    state_d = ST_DONE;
                else
                    state_d = mode_q ? ST_WR : ST_RD;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_read   = (state_q == ST_RD);
        mem_write  = (state_q == ST_WR);
        busy       = mem_read || mem_write;
        done       = (state_q == ST_DONE);
        addr       = '0;
        write_data = '0;
        if (mem_read)
            addr = src_q;
        if (mem_write) begin
            addr       = dst_q;
            write_data = mode_q ? fill_q : data_q;
        end
    end

    assign words_done = words_q;

endmodule

// File: tb/tb_mem_dma_engine.sv
// Directed plus randomized bench for mem_dma_engine against a word-level memory model.
module tb_mem_dma_engine;

    localparam int AW    = 19;
    localparam int DW    = 19;
    localparam int LW    = 11;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start, mode, abort;
    logic [AW-1:0] src_addr, dst_addr, addr;
    logic [LW-1:0] length, words_done;
    logic [DW-1:0] fill_data, write_data, read_data;
    logic          mem_read, mem_write, busy, done;

    always #5 clk = ~clk;

    mem_dma_engine #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
        .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
        .fill_data(fill_data), .abort(abort), .mem_read(mem_read),
        .mem_write(mem_write), .addr(addr), .write_data(write_data),
        .read_data(read_data), .busy(busy), .done(done), .words_done(words_done)
    );

    // Memory seen by the DUT, plus a bench-side write port for preloading.
    logic [DW-1:0] mem     [0:DEPTH-1];
    logic [DW-1:0] exp_mem [0:DEPTH-1];
    logic          init_en = 1'b0;
    logic          pk_en   = 1'b0;
    logic [AW-1:0] pk_addr = '0;
    logic [DW-1:0] pk_data = '0;

    function automatic logic [DW-1:0] init_val(input int a);
        return DW'(a * 7 + 3);
    endfunction

    always @(posedge clk) begin
        if (init_en) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= init_val(i);
        end else if (mem_write) begin
            mem[addr] <= write_data;
        end else if (pk_en) begin
            mem[pk_addr] <= pk_data;
        end
    end

    assign read_data = mem[addr];

    int checks   = 0;
    int failures = 0;
    logic [AW-1:0] wr_q[$];
    int rd_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pk_en = 1'b1; pk_addr = a; pk_data = d;
        tick();
        pk_en = 1'b0;
        exp_mem[a] = d;
    endtask

    // Whole transfer: drive start, watch every cycle, then compare memory with the model.
    task automatic run_xfer(input string tag, input logic m, input logic [AW-1:0] s,
                            input logic [AW-1:0] d, input int n, input logic [DW-1:0] f,
                            input bit garble);
        int done_cyc, both, idle_nz, busy_bad, lat, errs;
        logic [AW-1:0] a;
        done_cyc = -1; both = 0; idle_nz = 0; busy_bad = 0; errs = 0;
        wr_q.delete(); rd_cnt = 0;
        mode = m; src_addr = s; dst_addr = d; length = LW'(n); fill_data = f; start = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 1; cyc <= 2 * n + 10; cyc++) begin
            if (mem_read && mem_write) both++;
            if (!mem_read && !mem_write && (addr != '0 || write_data != '0)) idle_nz++;
            if (busy !== (mem_read || mem_write)) busy_bad++;
            if (mem_read) rd_cnt++;
            if (mem_write) wr_q.push_back(addr);
            if (done === 1'b1) begin
                done_cyc = cyc;
                break;
            end
            if (garble && cyc == 2) begin
                start = 1'b1; mode = ~m; src_addr = ~s; dst_addr = ~d;
                length = LW'(5); fill_data = ~f;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        lat = (n == 0) ? 1 : (m ? n + 1 : 2 * n + 1);
        chk({tag, "_latency"}, done_cyc, lat);
        chk({tag, "_words_done"}, words_done, n);
        chk({tag, "_both_strobes"}, both, 0);
        chk({tag, "_idle_bus_zero"}, idle_nz, 0);
        chk({tag, "_busy"}, busy_bad, 0);
        chk({tag, "_reads"}, rd_cnt, m ? 0 : n);
        chk({tag, "_writes"}, wr_q.size(), n);
        tick();
        chk({tag, "_done_one_cycle"}, {busy, done}, 2'b00);
        for (int i = 0; i < n; i++) begin
            a = d + AW'(i);
            exp_mem[a] = m ? f : exp_mem[s + AW'(i)];
        end
        for (int i = 0; i < n; i++) begin
            a = d + AW'(i);
            if (mem[a] !== exp_mem[a]) errs++;
        end
        chk({tag, "_mem"}, errs, 0);
    endtask

    initial begin
        int errs, wr_seen, bad;
        logic [AW-1:0] a;
        rst_n = 1'b0; start = 1'b0; mode = 1'b0; abort = 1'b0;
        src_addr = '0; dst_addr = '0; length = '0; fill_data = '0;
        for (int i = 0; i < DEPTH; i++) exp_mem[i] = init_val(i);
        init_en = 1'b1;
        tick();
        init_en = 1'b0;
        tick();
        chk("rst_outputs", {mem_read, mem_write, busy, done}, 4'b0000);
        chk("rst_addr", addr, 0);
        chk("rst_wdata", write_data, 0);
        chk("rst_words", words_done, 0);
        rst_n = 1'b1;
        tick();

        // Copy into the FFT region.
        poke(19'h00010, 19'h11); poke(19'h00011, 19'h22);
        poke(19'h00012, 19'h33); poke(19'h00013, 19'h44);
        run_xfer("copy4", 1'b0, 19'h00010, 19'h70000, 4, '0, 1'b0);
        chk("copy4_w3", mem[19'h70003], 19'h44);

        // Fill into the crypto region.
        run_xfer("fill3", 1'b1, '0, 19'h60000, 3, 19'h5A5A5, 1'b0);
        chk("fill3_w2", mem[19'h60002], 19'h5A5A5);

        run_xfer("len0", 1'b0, 19'h00100, 19'h00200, 0, '0, 1'b0);

        run_xfer("wrap", 1'b0, 19'h00020, 19'h7FFFF, 2, '0, 1'b0);
        chk("wrap_addr1", (wr_q.size() >= 2) ? 32'(wr_q[1]) : 32'hDEAD, 0);

        // start pulsed mid-transfer with different parameters must be ignored.
        run_xfer("busy_start", 1'b0, 19'h00500, 19'h00600, 5, '0, 1'b1);

        // Abort during the third write of an 8-word copy.
        mode = 1'b0; src_addr = 19'h01000; dst_addr = 19'h02000; length = LW'(8); start = 1'b1;
        tick();
        start = 1'b0;
        wr_seen = 0;
        for (int cyc = 0; cyc < 40 && wr_seen < 3; cyc++) begin
            if (mem_write) wr_seen++;
            if (wr_seen < 3) tick();
        end
        chk("abort_reached_wr3", wr_seen, 3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_state", {busy, done, mem_read, mem_write}, 4'b0000);
        chk("abort_words", words_done, 3);
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done || busy || mem_write) bad++;
        end
        chk("abort_quiet", bad, 0);
        for (int i = 0; i < 3; i++) exp_mem[19'h02000 + AW'(i)] = exp_mem[19'h01000 + AW'(i)];
        errs = 0;
        for (int i = 0; i < 8; i++) begin
            a = 19'h02000 + AW'(i);
            if (mem[a] !== exp_mem[a]) errs++;
        end
        chk("abort_mem", errs, 0);

        // Reset asserted in the middle of an RD cycle.
        mode = 1'b0; src_addr = 19'h03000; dst_addr = 19'h04000; length = LW'(6); start = 1'b1;
        tick();
        start = 1'b0;
        chk("rst_mid_in_rd", mem_read, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_strobes", {mem_read, mem_write, busy}, 3'b000);
        chk("rst_mid_addr", addr, 0);
        chk("rst_mid_words", words_done, 0);
        tick();
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done || busy || mem_read || mem_write) bad++;
        end
        chk("rst_mid_no_resume", bad, 0);
        chk("rst_mid_dst0", mem[19'h04000], exp_mem[19'h04000]);

        // Randomized transfers checked against the memory model.
        for (int t = 0; t < 10; t++) begin
            run_xfer($sformatf("rnd%0d", t), 1'($urandom_range(0, 1)),
                     AW'($urandom), AW'($urandom), int'($urandom_range(0, 12)),
                     DW'($urandom), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
